// File: rtl/p09_video_sequencer.sv
// Video timing sequencer: a prescaled pixel tick drives signed horizontal and
// vertical counters whose negative range covers porch/sync and whose
// non-negative range is the active picture. A three-state FSM starts, runs
// and drains the scan so that a stop request only takes effect on a frame
// boundary. All sync/blank/position outputs are decoded directly from the
// registered counters.
module p09_video_sequencer #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int DIV    = 2,
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL) + 1,
  localparam int VW      = $clog2(V_TOTAL) + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 fast_req_i,
  output logic                 running_o,
  output logic                 fast_mode_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 blank_o,
  output logic signed [HW-1:0] hpos_o,
  output logic signed [VW-1:0] vpos_o,
  output logic                 line_end_o,
  output logic                 frame_end_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Prescaler needs at least one bit even when every clock is a pixel.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]        PS_LAST   = PW'(DIV - 1);
  localparam logic signed [HW-1:0] H_INIT    = HW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [HW-1:0] H_LAST    = HW'(H_RES - 1);
  localparam logic signed [HW-1:0] H_SYNC_LO = HW'(-(H_SYNC + H_BP));
  localparam logic signed [HW-1:0] H_SYNC_HI = HW'(-H_BP);
  localparam logic signed [HW-1:0] H_STEP1   = HW'(1);
  localparam logic signed [HW-1:0] H_STEP4   = HW'(4);
  localparam logic signed [VW-1:0] V_INIT    = VW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [VW-1:0] V_LAST    = VW'(V_RES - 1);
  localparam logic signed [VW-1:0] V_SYNC_LO = VW'(-(V_SYNC + V_BP));
  localparam logic signed [VW-1:0] V_SYNC_HI = VW'(-V_BP);
  localparam logic signed [VW-1:0] V_STEP1   = VW'(1);

  state_t                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic signed [HW-1:0]   hpos_q,  hpos_d;
  logic signed [VW-1:0]   vpos_q,  vpos_d;
  logic                   fast_q,  fast_d;

  logic running;
  logic pix_en;
  logic h_wrap;
  logic v_last;
  logic f_wrap;
  logic h_in_sync;
  logic v_in_sync;

  // Scan events decoded from the registered state; the horizontal compare is
  // >= so a +4 step that overshoots the last active pixel still wraps.
  assign running   = (state_q != S_IDLE);
  assign pix_en    = running && (presc_q == PS_LAST);
  assign h_wrap    = pix_en && (hpos_q >= H_LAST);
  assign v_last    = (vpos_q >= V_LAST);
  assign f_wrap    = h_wrap && v_last;

  assign h_in_sync = (hpos_q >= H_SYNC_LO) && (hpos_q < H_SYNC_HI);
  assign v_in_sync = (vpos_q >= V_SYNC_LO) && (vpos_q < V_SYNC_HI);

  assign running_o   = running;
  assign fast_mode_o = fast_q;
  assign hsync_o     = (H_POL != 0) ? h_in_sync : !h_in_sync;
  assign vsync_o     = (V_POL != 0) ? v_in_sync : !v_in_sync;
  assign blank_o     = (hpos_q < 0) || (vpos_q < 0);
  assign hpos_o      = hpos_q;
  assign vpos_o      = vpos_q;
  assign line_end_o  = h_wrap;
  assign frame_end_o = f_wrap;

  // State, prescaler, counters and step mode registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hpos_q  <= H_INIT;
      vpos_q  <= V_INIT;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      fast_q  <= fast_d;
    end
  end

  // FSM next state; the step mode is only re-sampled at a start or a frame
  // boundary so a frame never changes pitch halfway through.
  always_comb begin
    state_d = state_q;
    fast_d  = fast_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          fast_d  = fast_req_i;
        end
      end
      S_RUN: begin
        if (stop_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (start_i)     state_d = S_RUN;
        else if (f_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (f_wrap) fast_d = fast_req_i;
  end

  // Prescaler and position counters. Leaving DRAIN on a frame boundary needs
  // no special case: the wrap itself reloads both counters and the prescaler
  // is already rolling back to zero on that same tick.
  always_comb begin
    presc_d = presc_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    if (running) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PW'(1);
    end
    if (h_wrap) begin
      hpos_d = H_INIT;
      vpos_d = v_last ? V_INIT : vpos_q + V_STEP1;
    end else if (pix_en) begin
      hpos_d = hpos_q + (fast_q ? H_STEP4 : H_STEP1);
    end
  end

endmodule

// File: tb/tb_p09_video_sequencer.sv
// Scoreboard bench for p09_video_sequencer using a small-raster configuration.
module tb_p09_video_sequencer;

  localparam int H_RES  = 4;
  localparam int H_FP   = 1;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 1;
  localparam int V_RES  = 2;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 1;
  localparam int V_BP   = 1;
  localparam int H_POL  = 0;
  localparam int V_POL  = 0;
  localparam int DIV    = 2;
  localparam int HW     = $clog2(H_RES + H_FP + H_SYNC + H_BP) + 1;
  localparam int VW     = $clog2(V_RES + V_FP + V_SYNC + V_BP) + 1;

  typedef struct packed {
    logic              run;
    logic              fast;
    logic              hs;
    logic              vs;
    logic              blank;
    logic              le;
    logic              fe;
    logic signed [7:0] hp;
    logic signed [7:0] vp;
  } obs_t;

  logic clk;
  logic reset_i, start_i, stop_i, fast_req_i;
  logic running_o, fast_mode_o, hsync_o, vsync_o, blank_o;
  logic signed [HW-1:0] hpos_o;
  logic signed [VW-1:0] vpos_o;
  logic line_end_o, frame_end_o;

  int n_checks = 0;
  int n_errors = 0;

  obs_t sb_q[$];

  // Reference model: scan position as plain integers, mode 0 idle/1 run/2 drain.
  int m_mode, m_presc, m_h, m_v;
  bit m_fast;
  bit prev_r;

  p09_video_sequencer #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .DIV(DIV)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .fast_req_i(fast_req_i), .running_o(running_o), .fast_mode_o(fast_mode_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
    .hpos_o(hpos_o), .vpos_o(vpos_o),
    .line_end_o(line_end_o), .frame_end_o(frame_end_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_init();
    m_mode  = 0;
    m_presc = 0;
    m_h     = -(H_FP + H_SYNC + H_BP);
    m_v     = -(V_FP + V_SYNC + V_BP);
    m_fast  = 1'b0;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    bit pe, hin, vin;
    pe      = (m_mode != 0) && (m_presc == DIV - 1);
    hin     = (m_h >= -(H_SYNC + H_BP)) && (m_h < -H_BP);
    vin     = (m_v >= -(V_SYNC + V_BP)) && (m_v < -V_BP);
    e.run   = (m_mode != 0);
    e.fast  = m_fast;
    e.hs    = (H_POL != 0) ? hin : !hin;
    e.vs    = (V_POL != 0) ? vin : !vin;
    e.blank = (m_h < 0) || (m_v < 0);
    e.le    = pe && (m_h >= H_RES - 1);
    e.fe    = e.le && (m_v >= V_RES - 1);
    e.hp    = 8'(m_h);
    e.vp    = 8'(m_v);
    return e;
  endfunction

  function automatic void model_step(bit s, bit p, bit f);
    obs_t cur;
    bit pe;
    cur = model_out();
    pe  = cur.run && (m_presc == DIV - 1);
    if (cur.run) begin
      m_presc = (m_presc + 1) % DIV;
      if (cur.le) begin
        m_h = -(H_FP + H_SYNC + H_BP);
        m_v = (m_v >= V_RES - 1) ? -(V_FP + V_SYNC + V_BP) : m_v + 1;
      end else if (pe) begin
        m_h = m_h + (m_fast ? 4 : 1);
      end
    end
    if (cur.fe) m_fast = f;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_fast = f; end
      1: if (p) m_mode = 2;
      default: begin
        if (s)           m_mode = 1;
        else if (cur.fe) m_mode = 0;
      end
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t g;
    g.run   = running_o;
    g.fast  = fast_mode_o;
    g.hs    = hsync_o;
    g.vs    = vsync_o;
    g.blank = blank_o;
    g.le    = line_end_o;
    g.fe    = frame_end_o;
    g.hp    = hpos_o;
    g.vp    = vpos_o;
    return g;
  endfunction

  task automatic report(input string name, input obs_t g, input obs_t e);
    $display("FAIL %s t=%0t got run=%0d fast=%0d hs=%0d vs=%0d blank=%0d le=%0d fe=%0d hpos=%0d vpos=%0d | exp run=%0d fast=%0d hs=%0d vs=%0d blank=%0d le=%0d fe=%0d hpos=%0d vpos=%0d",
             name, $time, g.run, g.fast, g.hs, g.vs, g.blank, g.le, g.fe, g.hp, g.vp,
             e.run, e.fast, e.hs, e.vs, e.blank, e.le, e.fe, e.hp, e.vp);
  endtask

  // One clock of stimulus: drive inputs on the falling edge and queue the
  // outputs expected after the next rising edge.
  task automatic step(input bit r, input bit s, input bit p, input bit f);
    obs_t g, e;
    @(negedge clk);
    reset_i = r; start_i = s; stop_i = p; fast_req_i = f;
    if (r) begin
      model_init();
      if (!prev_r) begin
        #1;
        g = sample();
        e = '{run: 1'b0, fast: 1'b0, hs: (H_POL == 0), vs: (V_POL == 0),
              blank: 1'b1, le: 1'b0, fe: 1'b0,
              hp: 8'(-(H_FP + H_SYNC + H_BP)), vp: 8'(-(V_FP + V_SYNC + V_BP))};
        n_checks++;
        if (g !== e) begin
          n_errors++;
          report("reset_async", g, e);
        end
      end
    end else begin
      model_step(s, p, f);
    end
    prev_r = r;
    sb_q.push_back(model_out());
  endtask

  // Monitor: the DUT presents a new output set every clock.
  initial begin
    obs_t g, e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = sample();
        n_checks++;
        if (g !== e) begin
          n_errors++;
          report("cycle_check", g, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got no end of stimulus, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit f_rand;
    int guard;
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; fast_req_i = 1'b0;
    prev_r = 1'b0;
    model_init();

    // Power-up reset, then stop is ignored while idle.
    repeat (3) step(1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0);

    // Single start pulse and two-plus frames at +1 step.
    step(0, 1, 0, 0);
    repeat (170) step(0, 0, 0, 0);

    // Request fast step mid-frame; it takes hold at the next frame boundary.
    repeat (200) step(0, 0, 0, 1);

    // Stop mid-frame and drain into idle.
    step(0, 0, 1, 0);
    repeat (120) step(0, 0, 0, 0);

    // Start, stop, then start again during drain.
    step(0, 1, 0, 0);
    repeat (50) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (20) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (150) step(0, 0, 0, 0);

    // Stop, then issue start exactly on the frame_end clock of the drain.
    step(0, 0, 1, 0);
    guard = 0;
    while (!model_out().fe && guard < 200) begin
      step(0, 0, 0, 0);
      guard++;
    end
    step(0, 1, 0, 0);
    repeat (100) step(0, 0, 0, 0);

    // Reset mid-line with start and stop held high; stay idle until start.
    repeat (7) step(0, 1, 1, 0);
    repeat (3) step(1, 1, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    repeat (90) step(0, 0, 0, 0);

    // Randomized traffic.
    f_rand = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) f_rand = ~f_rand;
      step(($urandom_range(499) == 0), ($urandom_range(39) == 0),
           ($urandom_range(59) == 0), f_rand);
    end
    step(0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending entries, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
